// File: rtl/wb_pbus_pkg.sv
// wb_pbus_pkg: shared constants for the Wishbone to peripheral-bus bridge
//   ST_IDLE/ST_ACCESS  access FSM encodings
//   RD_DEFAULT_BIT     fill value of wb_data_o when no read data is returned
//   entry_width()      width of one queued request {we, sel, adr, data}
package wb_pbus_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;
  localparam logic RD_DEFAULT_BIT = 1'b1;
  function automatic int entry_width(int aw, int dw);
    return aw + dw + dw / 8 + 1;
  endfunction
endpackage

// File: rtl/wb_pbus_if.sv
// wb_pbus_if: Wishbone slave side plus peripheral-bus side of the bridge
//   slave  : bridge view (Wishbone requests in, responses and peripheral strobes out)
//   master : environment view (Wishbone master and peripheral device)
interface wb_pbus_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  logic wb_cyc_i, wb_stb_i, wb_we_i;
  logic [SEL_WIDTH-1:0] wb_sel_i;
  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_data_i, wb_data_o;
  logic wb_ack_o, wb_error_o, wb_stall_o;
  logic peripheralBus_we, peripheralBus_oe, peripheralBus_busy;
  logic [ADDR_WIDTH-1:0] peripheralBus_address;
  logic [SEL_WIDTH-1:0] peripheralBus_byteSelect;
  logic [DATA_WIDTH-1:0] peripheralBus_dataRead, peripheralBus_dataWrite;
  modport slave (
    input wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input peripheralBus_busy, peripheralBus_dataRead,
    output wb_ack_o, wb_error_o, wb_stall_o, wb_data_o,
    output peripheralBus_we, peripheralBus_oe, peripheralBus_address,
    output peripheralBus_byteSelect, peripheralBus_dataWrite
  );
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output peripheralBus_busy, peripheralBus_dataRead,
    input wb_ack_o, wb_error_o, wb_stall_o, wb_data_o,
    input peripheralBus_we, peripheralBus_oe, peripheralBus_address,
    input peripheralBus_byteSelect, peripheralBus_dataWrite
  );
endinterface

// File: rtl/wb_pbus_req_fifo.sv
// wb_pbus_req_fifo: synchronous request FIFO (DEPTH power of 2)
//   clk, rst_n (sync, active-low), push/pop/flush, din -> dout (head entry), full/empty
module wb_pbus_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/wb_peripheral_bus_bridge.sv
// wb_peripheral_bus_bridge: pipelined Wishbone slave to single-access peripheral bus
//   wb_clk_i  : clock
//   wb_rst_n_i: synchronous active-low reset
//   bus       : wb_pbus_if.slave (Wishbone request/response + peripheral strobes)
//   Optional macro WB_PBUS_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES busy cycles
//   and answer it with wb_error_o instead of wb_ack_o.
module wb_peripheral_bus_bridge
  import wb_pbus_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic wb_clk_i,
  input logic wb_rst_n_i,
  wb_pbus_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  logic [EW-1:0] head;
  logic [0:0] state;
  logic push, pop, full, empty, access, done, timeout, respond, abandon;
  logic cur_we;
  logic [SW-1:0] cur_sel;
  logic [ADDR_WIDTH-1:0] cur_adr;
  logic [DATA_WIDTH-1:0] cur_dat;
  assign access = state == ST_ACCESS;
  assign push = bus.wb_cyc_i & bus.wb_stb_i & ~full;
  assign pop = ~access & ~empty & bus.wb_cyc_i;
  assign done = access & ~bus.peripheralBus_busy;
  // an access outlives a dropped cycle, but its answer belongs to nobody
  assign respond = bus.wb_cyc_i & ~abandon;
  assign bus.wb_stall_o = full;
  assign bus.peripheralBus_we = access & cur_we;
  assign bus.peripheralBus_oe = access & ~cur_we;
  assign bus.peripheralBus_address = access ? cur_adr : '0;
  assign bus.peripheralBus_byteSelect = access ? cur_sel : '0;
  assign bus.peripheralBus_dataWrite = access & cur_we ? cur_dat : '0;
  wb_pbus_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i),
    .rst_n(wb_rst_n_i),
    .push(push),
    .pop(pop),
    .flush(~bus.wb_cyc_i),
    .din({bus.wb_we_i, bus.wb_sel_i, bus.wb_adr_i, bus.wb_data_i}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
      abandon <= 1'b0;
      bus.wb_ack_o <= 1'b0;
      bus.wb_data_o <= {DATA_WIDTH{RD_DEFAULT_BIT}};
    end else begin
      bus.wb_ack_o <= done & respond;
      bus.wb_data_o <= done & ~cur_we ? bus.peripheralBus_dataRead : {DATA_WIDTH{RD_DEFAULT_BIT}};
      if (pop) begin
        state <= ST_ACCESS;
        {cur_we, cur_sel, cur_adr, cur_dat} <= head;
      end else if (done | timeout) state <= ST_IDLE;
      abandon <= pop ? 1'b0 : abandon | (access & ~bus.wb_cyc_i);
    end
  end
`ifdef WB_PBUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] busy_cnt;
  // fires on the busy cycle that would make the count reach TIMEOUT_CYCLES
  assign timeout = access & bus.peripheralBus_busy & (busy_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge wb_clk_i) begin
    busy_cnt <= (!wb_rst_n_i || pop || timeout) ? '0 : busy_cnt + TW'(access & bus.peripheralBus_busy);
    bus.wb_error_o <= wb_rst_n_i & timeout & respond;
  end
`else
  assign timeout = 1'b0;
  assign bus.wb_error_o = 1'b0;
`endif
endmodule

// File: tb/tb_wb_peripheral_bus_bridge.sv
// tb_wb_peripheral_bus_bridge: directed and randomized checks of the bridge against a memory model
module tb_wb_peripheral_bus_bridge;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [DW-1:0] ONES = '1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  wb_pbus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  wb_peripheral_bus_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .bus(bus)
  );
  typedef struct packed {
    logic we;
    logic [SW-1:0] sel;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } req_t;
  req_t issue_q[$];
  logic [DW-1:0] resp_q[$];
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] pmem [4];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic we, input logic [AW-1:0] adr, input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_data_i = dat;
  endtask
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [SW-1:0] sel);
    logic [DW-1:0] res = old;
    for (int b = 0; b < SW; b++) if (sel[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction
  initial begin
    req_t r;
    bit act;
    bit prev_act = 1'b0;
    logic [1:0] idx;
    int gen = 0;
    int n = 0;
    int busy_run = 0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_data_i = '0;
    bus.peripheralBus_busy = 1'b0;
    bus.peripheralBus_dataRead = '0;
    repeat (3) step();
    chk("rst_ack", bus.wb_ack_o, 0);
    chk("rst_err", bus.wb_error_o, 0);
    chk("rst_stall", bus.wb_stall_o, 0);
    chk("rst_data", bus.wb_data_o, ONES);
    chk("rst_we_oe", {bus.peripheralBus_we, bus.peripheralBus_oe}, 0);
    chk("rst_addr", bus.peripheralBus_address, 0);
    chk("rst_sel", bus.peripheralBus_byteSelect, 0);
    chk("rst_wdata", bus.peripheralBus_dataWrite, 0);
    rst_n = 1'b1;
    step();
    // single write, peripheral ready
    req(1'b1, 24'h000010, 4'hF, 32'hDEADBEEF);
    step();
    bus.wb_stb_i = 1'b0;
    chk("wr_idle_we", bus.peripheralBus_we, 0);
    step();
    chk("wr_we", bus.peripheralBus_we, 1);
    chk("wr_oe", bus.peripheralBus_oe, 0);
    chk("wr_addr", bus.peripheralBus_address, 24'h000010);
    chk("wr_wdata", bus.peripheralBus_dataWrite, 32'hDEADBEEF);
    chk("wr_sel", bus.peripheralBus_byteSelect, 4'hF);
    chk("wr_early_ack", bus.wb_ack_o, 0);
    step();
    chk("wr_ack", bus.wb_ack_o, 1);
    chk("wr_err", bus.wb_error_o, 0);
    chk("wr_we_drop", bus.peripheralBus_we, 0);
    chk("wr_data_ones", bus.wb_data_o, ONES);
    step();
    chk("wr_ack_pulse", bus.wb_ack_o, 0);
    // read with 4 busy cycles
    bus.peripheralBus_busy = 1'b1;
    bus.peripheralBus_dataRead = 32'h12345678;
    req(1'b0, 24'h000020, 4'hF, 32'h0);
    step();
    bus.wb_stb_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("rd_oe_held", bus.peripheralBus_oe, 1);
      chk("rd_no_ack", bus.wb_ack_o, 0);
      chk("rd_wdata_zero", bus.peripheralBus_dataWrite, 0);
      if (i == 4) bus.peripheralBus_busy = 1'b0;
      step();
    end
    chk("rd_ack", bus.wb_ack_o, 1);
    chk("rd_data", bus.wb_data_o, 32'h12345678);
    chk("rd_oe_drop", bus.peripheralBus_oe, 0);
    // stall: A in flight, B and C fill the FIFO
    bus.peripheralBus_busy = 1'b1;
    req(1'b1, 24'h000030, 4'hF, 32'h1);
    step();
    bus.wb_stb_i = 1'b0;
    step();
    chk("st_a_addr", bus.peripheralBus_address, 24'h000030);
    chk("st_stall0", bus.wb_stall_o, 0);
    req(1'b1, 24'h000034, 4'hF, 32'h2);
    step();
    chk("st_stall1", bus.wb_stall_o, 0);
    req(1'b1, 24'h000038, 4'hF, 32'h3);
    step();
    bus.wb_stb_i = 1'b0;
    chk("st_full", bus.wb_stall_o, 1);
    step();
    chk("st_full_hold", bus.wb_stall_o, 1);
    chk("st_a_held", bus.peripheralBus_address, 24'h000030);
    bus.peripheralBus_busy = 1'b0;
    step();
    chk("st_ack_a", bus.wb_ack_o, 1);
    chk("st_full_on_pop", bus.wb_stall_o, 1);
    step();
    chk("st_ack_gap", bus.wb_ack_o, 0);
    chk("st_stall_clear", bus.wb_stall_o, 0);
    chk("st_b_issue", {bus.peripheralBus_we, bus.peripheralBus_address}, {1'b1, 24'h000034});
    step();
    chk("st_ack_b", bus.wb_ack_o, 1);
    step();
    chk("st_c_issue", {bus.peripheralBus_we, bus.peripheralBus_address}, {1'b1, 24'h000038});
    step();
    chk("st_ack_c", bus.wb_ack_o, 1);
    step();
    chk("st_done", {bus.wb_ack_o, bus.peripheralBus_we}, 0);
    // cyc dropped with one in flight and one queued
    bus.peripheralBus_busy = 1'b1;
    req(1'b1, 24'h000040, 4'hF, 32'h4);
    step();
    req(1'b1, 24'h000044, 4'hF, 32'h5);
    step();
    bus.wb_stb_i = 1'b0;
    chk("cyc_d_issue", bus.peripheralBus_address, 24'h000040);
    bus.wb_cyc_i = 1'b0;
    step();
    chk("cyc_inflight", {bus.peripheralBus_we, bus.peripheralBus_address}, {1'b1, 24'h000040});
    chk("cyc_stall", bus.wb_stall_o, 0);
    bus.wb_cyc_i = 1'b1;
    bus.peripheralBus_busy = 1'b0;
    step();
    chk("cyc_no_ack", bus.wb_ack_o, 0);
    for (int i = 0; i < 4; i++) begin
      chk("cyc_flushed", {bus.peripheralBus_we, bus.peripheralBus_oe, bus.wb_ack_o}, 0);
      step();
    end
    // reset during an access
    bus.peripheralBus_busy = 1'b1;
    req(1'b0, 24'h000050, 4'hF, 32'h0);
    step();
    req(1'b1, 24'h000054, 4'hF, 32'h55);
    step();
    bus.wb_stb_i = 1'b0;
    chk("rs_oe", bus.peripheralBus_oe, 1);
    rst_n = 1'b0;
    step();
    chk("rs_strobes", {bus.peripheralBus_we, bus.peripheralBus_oe}, 0);
    chk("rs_stall", bus.wb_stall_o, 0);
    chk("rs_ack", bus.wb_ack_o, 0);
    chk("rs_data", bus.wb_data_o, ONES);
    rst_n = 1'b1;
    bus.peripheralBus_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rs_quiet", {bus.peripheralBus_we, bus.peripheralBus_oe, bus.wb_ack_o}, 0);
    end
`ifdef WB_PBUS_TIMEOUT_EN
    // busy stuck: error after 8 busy cycles, then a normal read
    bus.peripheralBus_busy = 1'b1;
    req(1'b1, 24'h000060, 4'hF, 32'h66);
    step();
    bus.wb_stb_i = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("to_waiting", {bus.peripheralBus_we, bus.wb_error_o, bus.wb_ack_o}, 3'b100);
      step();
    end
    chk("to_err", bus.wb_error_o, 1);
    chk("to_no_ack", bus.wb_ack_o, 0);
    chk("to_we_drop", bus.peripheralBus_we, 0);
    chk("to_data", bus.wb_data_o, ONES);
    step();
    chk("to_err_pulse", bus.wb_error_o, 0);
    bus.peripheralBus_busy = 1'b0;
    bus.peripheralBus_dataRead = 32'hCAFEF00D;
    req(1'b0, 24'h000070, 4'hF, 32'h0);
    step();
    bus.wb_stb_i = 1'b0;
    step();
    chk("to_next_oe", bus.peripheralBus_oe, 1);
    step();
    chk("to_next_ack", bus.wb_ack_o, 1);
    chk("to_next_data", bus.wb_data_o, 32'hCAFEF00D);
`endif
    // randomized traffic against a byte-enabled memory model
    for (int i = 0; i < 4; i++) begin
      ref_mem[i] = DW'(32'h11111111 * (i + 1));
      pmem[i] = ref_mem[i];
    end
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b0;
    while ((gen < 60 || resp_q.size() != 0) && n < 3000) begin
      if (bus.wb_ack_o) begin
        if (resp_q.size() == 0) chk("rnd_spurious_ack", bus.wb_ack_o, 0);
        else chk("rnd_ack_data", bus.wb_data_o, resp_q.pop_front());
      end
      if (bus.wb_error_o) chk("rnd_error", bus.wb_error_o, 0);
      act = bus.peripheralBus_we | bus.peripheralBus_oe;
      if (act && !prev_act) begin
        if (issue_q.size() == 0) chk("rnd_spurious_issue", act, 0);
        else begin
          r = issue_q.pop_front();
          chk("rnd_issue",
              {bus.peripheralBus_we, bus.peripheralBus_byteSelect, bus.peripheralBus_address, bus.peripheralBus_dataWrite},
              {r.we, r.sel, r.adr, (r.we ? r.dat : {DW{1'b0}})});
        end
      end
      prev_act = act;
      if (act) begin
        bus.peripheralBus_busy = busy_run < 3 && $urandom_range(0, 1) == 1;
        busy_run = bus.peripheralBus_busy ? busy_run + 1 : 0;
        idx = bus.peripheralBus_address[3:2];
        bus.peripheralBus_dataRead = pmem[idx];
        if (!bus.peripheralBus_busy && bus.peripheralBus_we)
          pmem[idx] = merge(pmem[idx], bus.peripheralBus_dataWrite, bus.peripheralBus_byteSelect);
      end else begin
        bus.peripheralBus_busy = $urandom_range(0, 1) == 1;
        busy_run = 0;
        bus.peripheralBus_dataRead = $urandom;
      end
      bus.wb_stb_i = 1'b0;
      if (gen < 60 && !bus.wb_stall_o && $urandom_range(0, 2) != 0) begin
        r.we = $urandom_range(0, 1) == 1;
        r.sel = SW'($urandom);
        r.adr = AW'(24'h000100 + 4 * $urandom_range(0, 3));
        r.dat = $urandom;
        req(r.we, r.adr, r.sel, r.dat);
        issue_q.push_back(r);
        idx = r.adr[3:2];
        if (r.we) begin
          ref_mem[idx] = merge(ref_mem[idx], r.dat, r.sel);
          resp_q.push_back(ONES);
        end else resp_q.push_back(ref_mem[idx]);
        gen++;
      end
      step();
      n++;
    end
    chk("rnd_drained", resp_q.size(), 0);
    chk("rnd_all_issued", issue_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
